// File: rtl/imm_gen_stage.sv
// Immediate generator with a 2-entry skid FIFO between decode and execute.
// Build option: define IMM_GEN_CSR_EN to make ext_op=7 produce the CSR zimm instead of an error entry.
module imm_gen_stage #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [2:0]       ext_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_err
);

   if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_stage: XLEN must be 32 or 64");
   end

   logic [XLEN-1:0]  w_imm;
   logic             w_err;
   logic             w_push;
   logic             w_pop;
   logic             w_unused_opcode;

   logic [XLEN-1:0]  r_imm [2];
   logic [TAG_W-1:0] r_tag [2];
   logic             r_err [2];
   logic             r_wp;
   logic             r_rp;
   logic [1:0]       r_cnt;

   // Opcode bits never feed any immediate format.
   assign w_unused_opcode = &{1'b0, instr[6:0]};

   always_comb begin
      w_imm = '0;
      w_err = 1'b0;
      case (ext_op)
         3'd1: begin
            if (XLEN == 64) w_imm = {{(XLEN-6){1'b0}}, instr[25:20]};
            else            w_imm = {{(XLEN-5){1'b0}}, instr[24:20]};
         end
         3'd2: w_imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
         3'd3: w_imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
         3'd4: w_imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                        instr[11:8], 1'b0};
         3'd5: w_imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
         3'd6: w_imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                        instr[30:21], 1'b0};
         3'd7: begin
`ifdef IMM_GEN_CSR_EN
            w_imm = {{(XLEN-5){1'b0}}, instr[19:15]};
`else
            w_err = 1'b1;
`endif
         end
         default: ;
      endcase
   end

   // in_ready looks only at registered occupancy so no comb path from out_ready.
   assign in_ready  = (r_cnt != 2'd2);
   assign out_valid = (r_cnt != 2'd0);
   assign w_push    = in_valid & in_ready;
   assign w_pop     = out_valid & out_ready;

   assign imm     = out_valid ? r_imm[r_rp] : '0;
   assign out_tag = out_valid ? r_tag[r_rp] : '0;
   assign out_err = out_valid ? r_err[r_rp] : 1'b0;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_cnt <= 2'd0;
         r_wp  <= 1'b0;
         r_rp  <= 1'b0;
         for (int i = 0; i < 2; i++) begin
            r_imm[i] <= '0;
            r_tag[i] <= '0;
            r_err[i] <= 1'b0;
         end
      end else if (flush) begin
         r_cnt <= 2'd0;
         r_wp  <= 1'b0;
         r_rp  <= 1'b0;
      end else begin
         if (w_push) begin
            r_imm[r_wp] <= w_imm;
            r_tag[r_wp] <= in_tag;
            r_err[r_wp] <= w_err;
            r_wp        <= ~r_wp;
         end
         if (w_pop) r_rp <= ~r_rp;
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imm_gen_stage.sv
// Randomized and directed bench for imm_gen_stage against a queue-based reference model.
module tb_imm_gen_stage;
   localparam int XLEN  = 32;
   localparam int TAG_W = 5;

   logic             clk, rstn, flush, in_valid, in_ready, out_valid, out_ready, out_err;
   logic [31:0]      instr;
   logic [2:0]       ext_op;
   logic [TAG_W-1:0] in_tag, out_tag;
   logic [XLEN-1:0]  imm;

   int n_chk = 0;
   int n_pass = 0;

   typedef struct {
      logic [XLEN-1:0]  imm;
      logic [TAG_W-1:0] tag;
      logic             err;
   } ent_t;
   ent_t q[$];

   imm_gen_stage #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .instr(instr), .ext_op(ext_op), .in_tag(in_tag), .out_valid(out_valid),
      .out_ready(out_ready), .imm(imm), .out_tag(out_tag), .out_err(out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference immediate from the ISA field rules using 64-bit integer arithmetic.
   function automatic ent_t model(input logic [31:0] ins, input logic [2:0] op,
                                  input logic [TAG_W-1:0] tg);
      ent_t   e;
      longint s, u, v;
      logic [63:0] vv;
      s = longint'(signed'(ins));
      u = longint'({32'b0, ins});
      v = 0;
      e.err = 1'b0;
      case (op)
         3'd1: v = (XLEN == 64) ? ((u >> 20) & 63) : ((u >> 20) & 31);
         3'd2: v = s >>> 20;
         3'd3: v = (s >>> 25) * 32 + ((u >> 7) & 31);
         3'd4: v = (s >>> 31) * 4096 + ((u >> 7) & 1) * 2048 + ((u >> 25) & 63) * 32
                   + ((u >> 8) & 15) * 2;
         3'd5: v = (s >>> 12) * 4096;
         3'd6: v = (s >>> 31) * 1048576 + ((u >> 12) & 255) * 4096 + ((u >> 20) & 1) * 2048
                   + ((u >> 21) & 1023) * 2;
         3'd7: begin
`ifdef IMM_GEN_CSR_EN
            v = (u >> 15) & 31;
`else
            e.err = 1'b1;
`endif
         end
         default: v = 0;
      endcase
      vv = 64'(v);
      e.imm = vv[XLEN-1:0];
      e.tag = tg;
      return e;
   endfunction

   function automatic logic [XLEN-1:0] sx32(input logic [31:0] x);
      logic [63:0] t;
      t = {{32{x[31]}}, x};
      return t[XLEN-1:0];
   endfunction

   function automatic logic e_vld();
      return q.size() != 0;
   endfunction
   function automatic logic [XLEN-1:0] e_imm();
      return (q.size() != 0) ? q[0].imm : '0;
   endfunction
   function automatic logic [TAG_W-1:0] e_tag();
      return (q.size() != 0) ? q[0].tag : '0;
   endfunction
   function automatic logic e_err();
      return (q.size() != 0) ? q[0].err : 1'b0;
   endfunction

   // Applies one cycle of inputs, advances the model at the edge, leaves time at edge+1.
   task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] op,
                        input logic [TAG_W-1:0] tg, input logic ordy, input logic fl);
      bit full, pop;
      in_valid = v; instr = ins; ext_op = op; in_tag = tg; out_ready = ordy; flush = fl;
      full = (q.size() == 2);
      pop  = (q.size() != 0) && ordy;
      @(posedge clk);
      if (fl) q.delete();
      else begin
         if (pop) void'(q.pop_front());
         if (v && !full) q.push_back(model(ins, op, tg));
      end
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0; flush = 0; in_valid = 0; instr = 0; ext_op = 0; in_tag = 0; out_ready = 0;
      #2;
      n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid got=%b exp=0", out_valid); else n_pass++;
      n_chk++; if (imm !== '0) $display("FAIL rst_imm got=%h exp=0", imm); else n_pass++;
      n_chk++; if (out_tag !== '0) $display("FAIL rst_tag got=%h exp=0", out_tag); else n_pass++;
      n_chk++; if (out_err !== 1'b0) $display("FAIL rst_err got=%b exp=0", out_err); else n_pass++;
      n_chk++; if (in_ready !== 1'b1) $display("FAIL rst_ready got=%b exp=1", in_ready); else n_pass++;
      #10 rstn = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_i_imm();
      drive(1, 32'hFFF00093, 3'd2, 5'd7, 0, 0);
      n_chk++; if (out_valid !== 1'b1) $display("FAIL i_valid got=%b exp=1", out_valid); else n_pass++;
      n_chk++; if (imm !== {XLEN{1'b1}}) $display("FAIL i_imm got=%h exp=all-ones", imm); else n_pass++;
      n_chk++; if (out_tag !== 5'd7) $display("FAIL i_tag got=%0d exp=7", out_tag); else n_pass++;
      drive(0, 0, 0, 0, 1, 0);
      n_chk++; if (out_valid !== 1'b0) $display("FAIL i_drain got=%b exp=0", out_valid); else n_pass++;
   endtask

   task automatic test_back_to_back();
      logic [31:0] ins [5] = '{32'hFE20AE23, 32'hFE000EE3, 32'h123450B7, 32'h0080006F, 32'h00309093};
      logic [2:0]  ops [5] = '{3'd3, 3'd4, 3'd5, 3'd6, 3'd1};
      logic [31:0] exp [5] = '{32'hFFFFFFFC, 32'hFFFFFFFC, 32'h12345000, 32'h00000008, 32'h00000003};
      for (int i = 0; i < 5; i++) begin
         drive(1, ins[i], ops[i], 5'(i + 10), 1, 0);
         n_chk++; if (out_valid !== 1'b1 || imm !== sx32(exp[i]))
            $display("FAIL b2b_imm[%0d] got=%b/%h exp=1/%h", i, out_valid, imm, sx32(exp[i])); else n_pass++;
         n_chk++; if (out_tag !== 5'(i + 10) || in_ready !== 1'b1)
            $display("FAIL b2b_tag[%0d] got=%0d/%b exp=%0d/1", i, out_tag, in_ready, i + 10); else n_pass++;
      end
      drive(0, 0, 0, 0, 1, 0);
      n_chk++; if (out_valid !== 1'b0) $display("FAIL b2b_drain got=%b exp=0", out_valid); else n_pass++;
   endtask

   task automatic test_backpressure();
      drive(1, 32'h00100093, 3'd2, 5'd1, 0, 0);
      n_chk++; if (in_ready !== 1'b1 || out_tag !== 5'd1)
         $display("FAIL bp_1 got=%b/%0d exp=1/1", in_ready, out_tag); else n_pass++;
      drive(1, 32'h00200093, 3'd2, 5'd2, 0, 0);
      n_chk++; if (in_ready !== 1'b0 || out_tag !== 5'd1)
         $display("FAIL bp_full got=%b/%0d exp=0/1", in_ready, out_tag); else n_pass++;
      drive(1, 32'h00300093, 3'd2, 5'd3, 0, 0);
      n_chk++; if (in_ready !== 1'b0 || out_tag !== 5'd1 || imm !== XLEN'(1))
         $display("FAIL bp_hold got=%b/%0d/%h exp=0/1/1", in_ready, out_tag, imm); else n_pass++;
      drive(1, 32'h00300093, 3'd2, 5'd3, 1, 0);
      n_chk++; if (out_tag !== 5'd2 || imm !== XLEN'(2))
         $display("FAIL bp_rel2 got=%0d/%h exp=2/2", out_tag, imm); else n_pass++;
      drive(1, 32'h00300093, 3'd2, 5'd3, 1, 0);
      n_chk++; if (out_tag !== 5'd3 || imm !== XLEN'(3) || q.size() != 1)
         $display("FAIL bp_rel3 got=%0d/%h exp=3/3", out_tag, imm); else n_pass++;
      drive(0, 0, 0, 0, 1, 0);
      n_chk++; if (out_valid !== 1'b0) $display("FAIL bp_drain got=%b exp=0", out_valid); else n_pass++;
   endtask

   task automatic test_flush();
      drive(1, 32'h00500093, 3'd2, 5'd4, 0, 0);
      drive(1, 32'h00600093, 3'd2, 5'd5, 0, 0);
      n_chk++; if (in_ready !== 1'b0) $display("FAIL fl_full got=%b exp=0", in_ready); else n_pass++;
      drive(1, 32'h00700093, 3'd2, 5'd6, 1, 1);
      n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || imm !== '0)
         $display("FAIL fl_empty got=%b/%b/%h exp=0/1/0", out_valid, in_ready, imm); else n_pass++;
      drive(0, 0, 0, 0, 1, 0);
      n_chk++; if (out_valid !== 1'b0) $display("FAIL fl_nocap got=%b exp=0", out_valid); else n_pass++;
   endtask

   task automatic test_csr();
      drive(1, 32'h0002D073, 3'd7, 5'd9, 0, 0);
`ifdef IMM_GEN_CSR_EN
      n_chk++; if (imm !== XLEN'(5) || out_err !== 1'b0)
         $display("FAIL csr got=%h/%b exp=5/0", imm, out_err); else n_pass++;
`else
      n_chk++; if (imm !== '0 || out_err !== 1'b1)
         $display("FAIL csr got=%h/%b exp=0/1", imm, out_err); else n_pass++;
`endif
      drive(0, 0, 0, 0, 1, 0);
      n_chk++; if (out_valid !== 1'b0 || out_err !== 1'b0)
         $display("FAIL csr_pop got=%b/%b exp=0/0", out_valid, out_err); else n_pass++;
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), $urandom, 3'($urandom_range(0, 7)),
               5'($urandom), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0));
         n_chk++; if (out_valid !== e_vld() || in_ready !== (q.size() != 2))
            $display("FAIL rnd_hs[%0d] got=%b/%b exp=%b/%b", i, out_valid, in_ready, e_vld(), q.size() != 2);
         else n_pass++;
         n_chk++; if (imm !== e_imm() || out_tag !== e_tag() || out_err !== e_err())
            $display("FAIL rnd_data[%0d] got=%h/%0d/%b exp=%h/%0d/%b", i, imm, out_tag, out_err,
                     e_imm(), e_tag(), e_err());
         else n_pass++;
      end
      drive(0, 0, 0, 0, 1, 0);
      drive(0, 0, 0, 0, 1, 0);
   endtask

   task automatic test_async_reset();
      drive(1, 32'hFFF00093, 3'd2, 5'd3, 0, 0);
      n_chk++; if (out_valid !== 1'b1) $display("FAIL ar_pre got=%b exp=1", out_valid); else n_pass++;
      #2 rstn = 1'b0;
      q.delete();
      #1;
      n_chk++; if (out_valid !== 1'b0 || imm !== '0 || out_tag !== '0)
         $display("FAIL ar_now got=%b/%h/%0d exp=0/0/0", out_valid, imm, out_tag); else n_pass++;
      in_valid = 0;
      @(negedge clk) rstn = 1'b1;
      @(posedge clk); #1;
      n_chk++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL ar_post got=%b/%b exp=0/1", out_valid, in_ready); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_i_imm();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_csr();
      test_random();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, handshaked immediate generator for the decode→execute boundary of the pipelined RISC-V core.
- Per instruction: extracts and sign/zero-extends the immediate for the selected format, then buffers it with a passthrough tag in a 2-entry skid FIFO.
- Generalised to XLEN 32/64 with flush and backpressure.
- Sits between the decoder (instr + ext_op) and the ID/EX register / ALU operand mux.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 only (other values: elaboration error)
TAG_W, 5, width of the passthrough tag (rd or ROB index)

Ports:
clk  input  1  clock, rising edge
rstn  input  1  asynchronous active-low reset
flush  input  1  synchronous pipeline flush; empties the buffer
in_valid  input  1  decoder presents an instruction
in_ready  output  1  stage can accept
instr  input  32  raw instruction word
ext_op  input  3  format select: 0 none, 1 I-shamt, 2 I, 3 S, 4 B, 5 U, 6 J, 7 CSR-zimm
in_tag  input  TAG_W  passthrough tag
out_valid  output  1  head entry valid
out_ready  input  1  consumer accepts
imm  output  XLEN  extended immediate of head entry
out_tag  output  TAG_W  tag of head entry
out_err  output  1  head entry used an unsupported ext_op

Behaviour:
- Reset (rstn=0, asynchronous): FIFO count=0, read/write pointers=0, out_valid=0, imm=0, out_tag=0, out_err=0, in_ready=1.
- Immediate formation (combinational, before the buffer), sign bit instr[31] unless noted:
  - 0 none: 0.
  - 1 I-shamt: zero-extended. XLEN=32 uses instr[24:20]; XLEN=64 uses instr[25:20].
  - 2 I: sext(instr[31:20]).
  - 3 S: sext({instr[31:25],instr[11:7]}).
  - 4 B: sext({instr[31],instr[7],instr[30:25],instr[11:8],1'b0}).
  - 5 U: {instr[31:12],12'b0}, sign-extended to XLEN when XLEN=64.
  - 6 J: sext({instr[31],instr[19:12],instr[20],instr[30:21],1'b0}).
  - 7: see Optional Feature.
- Buffer: 2-entry FIFO; each entry holds {imm, tag, err}.
  - in_ready = (count != 2). Depends only on registered state, never on out_ready.
  - out_valid = (count != 0). imm, out_tag and out_err come from the head entry.
  - When out_valid=0, imm, out_tag and out_err hold 0.
- Push = in_valid & in_ready. Pop = out_valid & out_ready.
- Simultaneous push and pop: count unchanged, pointers advance. Permitted at count=1. At count=2, push is blocked by in_ready=0.
- Latency: an entry pushed at edge N is visible with out_valid=1 after edge N, i.e. a 1-cycle minimum.
- Full throughput of 1 per cycle when out_ready is held high.
- Pointers are 1 bit each and wrap 1→0.
- flush=1 at an edge: count=0, pointers=0. Flush overrides any push or pop in the same cycle. in_ready=1 on the next cycle.
- Reset asserted mid-transfer: all buffered entries are discarded immediately.
- Head data remains stable while out_valid=1 and out_ready=0.

Optional Feature:
Macro IMM_GEN_CSR_EN.
- Defined: ext_op=7 yields the CSR zimm, zero-extended instr[19:15], with err=0.
- Not defined: ext_op=7 yields imm=0 with err=1. The entry is still pushed and popped normally.
- All other ext_op values are identical in both builds.

Test Plan:
- Reset, then push instr=0xFFF00093, ext_op=2 → next cycle out_valid=1, imm=0xFFFFFFFF (XLEN=64: 0xFFFFFFFFFFFFFFFF).
- Back-to-back pushes with out_ready=1:
  - 0xFE20AE23/S → 0xFFFFFFFC
  - 0xFE000EE3/B → 0xFFFFFFFC
  - 0x123450B7/U → 0x12345000
  - 0x0080006F/J → 0x00000008
  - 0x00309093/I-shamt → 0x3
  - Outputs appear in order with one result per cycle.
- out_ready=0, push tags 1, 2, 3 → in_ready drops to 0 after two accepts. Tag 3 is held at the input. out_tag=1 holds stable. Release out_ready → tags 1, 2, 3 emerge in order.
- Buffer holding 2 entries, flush=1 together with in_valid=1 → next cycle out_valid=0, in_ready=1; the flushed-cycle instruction is not captured.
- ext_op=7, instr=0x0002D073 (zimm=5):
  - Without IMM_GEN_CSR_EN → imm=0, out_err=1.
  - With IMM_GEN_CSR_EN → imm=5, out_err=0.
- Assert rstn=0 asynchronously between edges while count=1 → out_valid and imm go to 0 immediately, before the next clk edge.
